// File: rtl/radio_pkg.sv
// radio_pkg
// Shared definitions for the RC receiver PWM capture block: channel count,
// default timing limits, value/counter widths, the per-channel FSM state
// type, the failsafe table and the width-to-stick-value conversion.
// Optional feature macro: RADIO_FAILSAFE_EN (consumes FAILSAFE_VAL).
package radio_pkg;

  localparam int NCH            = 8;
  localparam int VAL_W          = 10;      // published stick value width
  localparam int WIDTH_W        = 12;      // pulse width counter, saturates at 4095
  localparam int TO_W           = 17;      // timeout counter, saturates

  localparam int MIN_US_DEF     = 800;
  localparam int MAX_US_DEF     = 2200;
  localparam int OFFSET_US_DEF  = 1000;
  localparam int SPAN_DEF       = 1000;
  localparam int TIMEOUT_US_DEF = 100000;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    HIGH,
    EVAL
  } ch_state_e;

  // Value loaded on loss of signal; channel 2 is throttle and must go to 0.
  localparam logic [VAL_W-1:0] FAILSAFE_VAL [NCH] = '{
    10'd500, 10'd500, 10'd0, 10'd500, 10'd500, 10'd500, 10'd500, 10'd500
  };

  // Map an accepted pulse width to a stick value clamped to 0..span.
  function automatic logic [VAL_W-1:0] width_to_value(
    input logic [WIDTH_W-1:0] width,
    input int                 offset_us,
    input int                 span
  );
    logic [WIDTH_W-1:0] diff;
    if (width < WIDTH_W'(offset_us)) begin
      return '0;
    end
    diff = width - WIDTH_W'(offset_us);
    if (diff > WIDTH_W'(span)) begin
      return VAL_W'(span);
    end
    return diff[VAL_W-1:0];
  endfunction

endpackage

// File: rtl/radio_pwm_channel.sv
// radio_pwm_channel
// One PWM input: 3-register synchronizer, measurement FSM, pulse width
// counter and loss-of-signal timeout counter.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tick_1us      1 MHz enable pulse
//   sig           raw asynchronous PWM line
//   value         last published stick value
//   valid         accepted pulse seen within TIMEOUT_US
//   update        one-clk pulse when value is rewritten
//   reject        one-clk pulse when a pulse is discarded as a glitch
// Optional feature macro: RADIO_FAILSAFE_EN (loads FS_VAL on timeout).
module radio_pwm_channel
  import radio_pkg::*;
#(
  parameter int MIN_US     = MIN_US_DEF,
  parameter int MAX_US     = MAX_US_DEF,
  parameter int OFFSET_US  = OFFSET_US_DEF,
  parameter int SPAN       = SPAN_DEF,
`ifdef RADIO_FAILSAFE_EN
  parameter logic [VAL_W-1:0] FS_VAL = '0,
`endif
  parameter int TIMEOUT_US = TIMEOUT_US_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1us,
  input  logic             sig,
  output logic [VAL_W-1:0] value,
  output logic             valid,
  output logic             update,
  output logic             reject
);

  // Synchronizer chain. Deliberately not reset: it keeps tracking the pad
  // during reset so that WAIT_LOW sees the true line level afterwards.
  logic sync1_reg, sync2_reg, sync3_reg;

  ch_state_e            state_reg, state_next;
  logic [WIDTH_W-1:0]   width_reg, width_next;
  logic [TO_W-1:0]      to_cnt_reg, to_cnt_next;
  logic [VAL_W-1:0]     value_reg, value_next;
  logic                 valid_reg, valid_next;
  logic                 update_reg, update_next;
  logic                 accept;
  logic                 to_hit;

  always_ff @(posedge clk) begin
    sync1_reg <= sig;
    sync2_reg <= sync1_reg;
    sync3_reg <= sync2_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= WAIT_LOW;
      width_reg  <= '0;
      to_cnt_reg <= '0;
      value_reg  <= '0;
      valid_reg  <= 1'b0;
      update_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      width_reg  <= width_next;
      to_cnt_reg <= to_cnt_next;
      value_reg  <= value_next;
      valid_reg  <= valid_next;
      update_reg <= update_next;
    end
  end

  assign to_hit = (to_cnt_reg >= TO_W'(TIMEOUT_US));

  // The FSM looks at the third sync stage; its state already encodes the
  // previous line level, so a level change in the expected direction is
  // the edge.
  always_comb begin
    state_next  = state_reg;
    width_next  = width_reg;
    to_cnt_next = to_cnt_reg;
    value_next  = value_reg;
    valid_next  = valid_reg;
    update_next = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;

    case (state_reg)
      WAIT_LOW: begin
        if (!sync3_reg) begin
          state_next = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (sync3_reg) begin
          width_next = '0;
          state_next = HIGH;
        end
      end
      HIGH: begin
        // A tick in the same clk as the falling edge still counts.
        if (tick_1us && (width_reg != '1)) begin
          width_next = width_reg + 1'b1;
        end
        if (width_reg > WIDTH_W'(MAX_US)) begin
          reject     = 1'b1;
          state_next = WAIT_LOW;
        end else if (!sync3_reg) begin
          state_next = EVAL;
        end
      end
      EVAL: begin
        if ((width_reg >= WIDTH_W'(MIN_US)) && (width_reg <= WIDTH_W'(MAX_US))) begin
          accept = 1'b1;
        end else begin
          reject = 1'b1;
        end
        state_next = WAIT_RISE;
      end
      default: state_next = WAIT_LOW;
    endcase

    // Timeout counter restarts on every accepted pulse.
    if (accept) begin
      to_cnt_next = '0;
    end else if (tick_1us && (to_cnt_reg != '1)) begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end

    if (accept) begin
      valid_next  = 1'b1;
      value_next  = width_to_value(width_reg, OFFSET_US, SPAN);
      update_next = 1'b1;
    end else if (to_hit) begin
      valid_next = 1'b0;
`ifdef RADIO_FAILSAFE_EN
      if (valid_reg) begin
        value_next  = FS_VAL;
        update_next = 1'b1;
      end
`endif
    end
  end

  assign value  = value_reg;
  assign valid  = valid_reg;
  assign update = update_reg;

endmodule

// File: rtl/radio_pwm_capture.sv
// radio_pwm_capture
// Measures the high time of NCH RC receiver PWM inputs and publishes each
// as a 10-bit stick value with per-channel validity for failsafe handling.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tick_1us      1 MHz enable pulse
//   radio_sig     raw receiver PWM lines (asynchronous)
//   radio_val     channel i in bits [10i+9:10i]
//   radio_valid   channel has an accepted pulse within TIMEOUT_US
//   radio_update  one-clk pulse when channel i's value is rewritten
//   glitch_cnt    saturating count of rejected pulses, all channels
// Optional feature macro: RADIO_FAILSAFE_EN (failsafe value on timeout).
module radio_pwm_capture
  import radio_pkg::*;
#(
  parameter int MIN_US     = MIN_US_DEF,
  parameter int MAX_US     = MAX_US_DEF,
  parameter int OFFSET_US  = OFFSET_US_DEF,
  parameter int SPAN       = SPAN_DEF,
  parameter int TIMEOUT_US = TIMEOUT_US_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1us,
  input  logic [NCH-1:0]       radio_sig,
  output logic [VAL_W*NCH-1:0] radio_val,
  output logic [NCH-1:0]       radio_valid,
  output logic [NCH-1:0]       radio_update,
  output logic [7:0]           glitch_cnt
);

  localparam int CNT_W = $clog2(NCH + 1);

  logic [NCH-1:0]   reject_vec;
  logic [CNT_W-1:0] rej_count;
  logic [8:0]       glitch_sum;
  logic [7:0]       glitch_cnt_reg, glitch_cnt_next;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      radio_pwm_channel #(
        .MIN_US     (MIN_US),
        .MAX_US     (MAX_US),
        .OFFSET_US  (OFFSET_US),
        .SPAN       (SPAN),
`ifdef RADIO_FAILSAFE_EN
        .FS_VAL     (FAILSAFE_VAL[gi]),
`endif
        .TIMEOUT_US (TIMEOUT_US)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .tick_1us (tick_1us),
        .sig      (radio_sig[gi]),
        .value    (radio_val[gi*VAL_W +: VAL_W]),
        .valid    (radio_valid[gi]),
        .update   (radio_update[gi]),
        .reject   (reject_vec[gi])
      );
    end
  endgenerate

  // Several channels may reject in the same clk; add them all, saturating.
  always_comb begin
    rej_count = '0;
    for (int i = 0; i < NCH; i++) begin
      rej_count = rej_count + CNT_W'(reject_vec[i]);
    end
    glitch_sum      = {1'b0, glitch_cnt_reg} + 9'(rej_count);
    glitch_cnt_next = glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt_reg <= '0;
    end else begin
      glitch_cnt_reg <= glitch_cnt_next;
    end
  end

  assign glitch_cnt = glitch_cnt_reg;

endmodule

// File: tb/tb_radio_pwm_capture.sv
// tb_radio_pwm_capture
// Directed bench for radio_pwm_capture. Stimulus pushes expected
// (channel, value) updates into a queue; a monitor pops and compares on
// every radio_update pulse. tick_1us fires every second clk, so a pulse of
// N us is 2N clk wide. The timeout is shortened to keep runtime small.
module tb_radio_pwm_capture;
  import radio_pkg::*;

  localparam int TB_TIMEOUT = 5000;

  typedef struct {
    int ch;
    int val;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick_1us = 1'b0;
  logic [NCH-1:0]       radio_sig = '0;
  logic [VAL_W*NCH-1:0] radio_val;
  logic [NCH-1:0]       radio_valid;
  logic [NCH-1:0]       radio_update;
  logic [7:0]           glitch_cnt;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  radio_pwm_capture #(.TIMEOUT_US(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1us     (tick_1us),
    .radio_sig    (radio_sig),
    .radio_val    (radio_val),
    .radio_valid  (radio_valid),
    .radio_update (radio_update),
    .glitch_cnt   (glitch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 tick_1us = ~tick_1us;
    end
  end

  function automatic int val_of(int ch);
    return int'(radio_val[ch*VAL_W +: VAL_W]);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic expect_upd(int ch, int val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_fs(int ch);
`ifdef RADIO_FAILSAFE_EN
    expect_upd(ch, int'(FAILSAFE_VAL[ch]));
`else
    if (ch < 0) $display("bad channel %0d", ch);
`endif
  endtask

  task automatic pulse(int ch, int us);
    @(posedge clk);
    #1 radio_sig[ch] = 1'b1;
    repeat (2 * us) @(posedge clk);
    #1 radio_sig[ch] = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  // Monitor: every update pulse must match the oldest expectation for
  // that channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (radio_update[ch]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++) begin
            if (idx < 0 && exp_q[k].ch == ch) idx = k;
          end
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_update ch%0d: got value %0d, none expected", ch, val_of(ch));
          end else begin
            check($sformatf("update_ch%0d", ch), val_of(ch), exp_q[idx].val);
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    int ones;
    int seen;
    int n;

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) check($sformatf("reset_val_ch%0d", ch), val_of(ch), 0);
    check("reset_valid", int'(radio_valid), 0);
    check("reset_update", int'(radio_update), 0);
    check("reset_glitch", int'(glitch_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // 1500 us on ch0: value 500, single update exactly 5 clk after the fall
    expect_upd(0, 500);
    expect_fs(0);
    @(posedge clk);
    #1 radio_sig[0] = 1'b1;
    repeat (3000) @(posedge clk);
    #1 radio_sig[0] = 1'b0;
    first_k = 0;
    ones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (radio_update[0]) begin
        ones++;
        if (first_k == 0) first_k = k;
      end
    end
    check("ch0_latency", first_k, 5);
    check("ch0_update_count", ones, 1);
    check("ch0_valid", int'(radio_valid[0]), 1);
    check("ch0_val", val_of(0), 500);

    // 900 us -> 0, 2100 us -> clamped 1000 on ch3
    expect_upd(3, 0);
    pulse(3, 900);
    @(negedge clk);
    check("ch3_val_900", val_of(3), 0);
    check("ch3_valid_900", int'(radio_valid[3]), 1);
    expect_upd(3, 1000);
    expect_fs(3);
    pulse(3, 2100);
    @(negedge clk);
    check("ch3_val_2100", val_of(3), 1000);
    check("ch3_valid_2100", int'(radio_valid[3]), 1);
    check("glitch_after_ch3", int'(glitch_cnt), 0);

    // ch5: good 1250 us, then 300 us runt and 3000 us stuck-high line
    expect_upd(5, 250);
    expect_fs(5);
    pulse(5, 1250);
    pulse(5, 300);
    @(negedge clk);
    check("glitch_after_runt", int'(glitch_cnt), 1);
    pulse(5, 3000);
    @(negedge clk);
    check("glitch_after_long", int'(glitch_cnt), 2);
    check("ch5_val_kept", val_of(5), 250);
    check("ch5_valid_kept", int'(radio_valid[5]), 1);

    // ch2 at 1800 us, ch1 at 1700 us, then both lines idle until timeout
    expect_upd(2, 800);
    expect_fs(2);
    pulse(2, 1800);
    expect_upd(1, 700);
    expect_fs(1);
    @(posedge clk);
    #1 radio_sig[1] = 1'b1;
    repeat (3400) @(posedge clk);
    #1 radio_sig[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen = int'(radio_update[1]);
    end
    check("ch1_update_seen", seen, 1);
    n = 0;
    while (n < TB_TIMEOUT) begin
      @(posedge clk);
      if (tick_1us) begin
        n++;
        if (n == TB_TIMEOUT - 1) begin
          @(negedge clk);
          check("ch1_valid_before_limit", int'(radio_valid[1]), 1);
        end
      end
    end
    @(negedge clk);
    check("ch1_valid_at_limit", int'(radio_valid[1]), 1);
    @(posedge clk);
    @(negedge clk);
    check("ch1_valid_after_limit", int'(radio_valid[1]), 0);
    check("ch2_valid_timed_out", int'(radio_valid[2]), 0);
`ifdef RADIO_FAILSAFE_EN
    check("ch1_val_timeout", val_of(1), 500);
    check("ch2_val_timeout", val_of(2), 0);
`else
    check("ch1_val_timeout", val_of(1), 700);
    check("ch2_val_timeout", val_of(2), 800);
`endif
    repeat (4) @(posedge clk);
    check("queue_drained_pre_reset", exp_q.size(), 0);

    // Reset 600 us into a 1500 us pulse on ch4
    @(posedge clk);
    #1 radio_sig[4] = 1'b1;
    repeat (1200) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_glitch", int'(glitch_cnt), 0);
    check("rst_mid_valid", int'(radio_valid), 0);
    check("rst_mid_val_ch0", val_of(0), 0);
    repeat (1800) @(posedge clk);
    #1 radio_sig[4] = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("ch4_no_partial", int'(radio_valid[4]), 0);
    check("ch4_val_after_rst", val_of(4), 0);
    expect_upd(4, 200);
    pulse(4, 1200);
    @(negedge clk);
    check("ch4_val_1200", val_of(4), 200);
    check("ch4_valid_1200", int'(radio_valid[4]), 1);
    check("glitch_final", int'(glitch_cnt), 0);
    check("queue_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
